mc_controlunit: RTL and testbench
=================================

# mc_controlunit

Multi-cycle RV32I control FSM replacing the single-cycle decoder in the next core. It sequences fetch, decode, execute, memory and writeback over a shared ALU and single memory port, waits on a memory ready handshake, resolves all six branch conditions, and keeps a retired-instruction counter.

## Interface
- `MEM_HANDSHAKE`, 1: 1 = stall in memory states until `mem_ready`; 0 = `mem_ready` ignored, treated as 1.
- `CNT_W`, 32: width of `instret`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  7  opcode from the instruction register.
- `funct3`  in  3  instruction funct3.
- `funct7_5`  in  1  instruction bit 30.
- `Zero`  in  1  ALU result == 0.
- `Lt`  in  1  signed A < B from the ALU.
- `Ltu`  in  1  unsigned A < B from the ALU.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `MemWrite`  out  1  the request is a write.
- `AdrSrc`  out  1  0 = PC, 1 = ALUOut as the memory address.
- `IRWrite`  out  1  latch the instruction and OldPC.
- `PCWrite`  out  1  load PC from the result mux.
- `RegWrite`  out  1  register file write.
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 rs1.
- `ALUSrcB`  out  2  00 rs2, 01 imm, 10 constant 4.
- `ResultSrc`  out  2  00 ALUOut, 01 read data, 10 ALU result.
- `ImmSrc`  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- `ALUControl`  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 pass B.
- `retire`  out  1  one-cycle pulse on instruction completion.
- `instret`  out  CNT_W  retired-instruction count.
- `illegal`  out  1  trap indicator (see Configuration).

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALWB, LUI, AUIPC, TRAP.
- FETCH:
  - outputs: `mem_req`=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - on the ready cycle: IRWrite=1 and PCWrite=1, then go to DECODE; otherwise hold.
- DECODE:
  - computes ALUOut = OldPC + B-immediate, or J-immediate for JAL.
  - next state by opcode: load/store→MEMADR, R→EXECR, I-ALU→EXECI, branch→BRANCH, JAL→JAL, JALR→JALR, LUI→LUI, AUIPC→AUIPC.
  - any other opcode→TRAP or FETCH (see Configuration).
- MEMADR: rs1 + immediate (I for loads, S for stores) → MEMRD for loads, MEMWR for stores.
- MEMRD: `mem_req`=1, AdrSrc=1; on ready → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWR: `mem_req`=1, MemWrite=1, AdrSrc=1; on ready → FETCH.
- EXECR/EXECI: ALU op from funct3, funct7_5 and the opcode.
  - sub only for R-type with funct7_5=1.
  - sra when funct3=101 and funct7_5=1.
  - next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: rs1 − rs2; PCWrite=1 with ResultSrc=00 when the condition holds; → FETCH.
  - beq Zero, bne !Zero, blt Lt, bge !Lt, bltu Ltu, bgeu !Ltu.
  - funct3 010/011 is never taken.
- JAL: PCWrite with ResultSrc=00; ALU computes OldPC+4 → ALUWB.
- JALR: rs1 + I-immediate, PCWrite with ResultSrc=10 → JALWB.
- JALWB: OldPC+4, ResultSrc=10, RegWrite → FETCH.
- LUI: ALUSrcB=imm (U), pass B → ALUWB.
- AUIPC: OldPC + U-immediate → ALUWB.
- `retire`:
  - pulses in ALUWB, MEMWB, BRANCH and JALWB.
  - also pulses in MEMWR on the ready cycle.
  - `instret` increments on each pulse and wraps 2^CNT_W−1 → 0.

## Timing
- Latency with `mem_ready` tied high:
  - branch 3 cycles.
  - R/I/LUI/AUIPC/JAL/JALR/store 4 cycles.
  - load 5 cycles.
- Each cycle of `mem_ready` low in FETCH, MEMRD or MEMWR adds one cycle.
- Moore outputs, except these, which are combinational on the current cycle's inputs:
  - FETCH IRWrite/PCWrite (on `mem_ready`).
  - BRANCH PCWrite (on the flags).
  - MEMWR `retire` (on `mem_ready`).
- `mem_req` stays high and the address stays stable until `mem_ready`; no request is dropped except by reset.
- While `rst_n` is low:
  - state = FETCH, `instret` = 0.
  - all strobes (mem_req, MemWrite, IRWrite, PCWrite, RegWrite, retire, illegal) = 0.
  - mux selects = 0.
- Reset asserted mid-instruction abandons it with no write and no retire; execution restarts at FETCH on the first edge after deassertion.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - an unknown opcode goes DECODE → TRAP.
  - TRAP holds `illegal`=1 and all strobes 0 until reset.
- Not defined:
  - an unknown opcode goes DECODE → FETCH as a no-op, with no retire.
  - TRAP is unreachable and `illegal` is tied 0.

## Test plan
- Reset, then `add` (op 0110011, funct3 000, funct7_5 0), `mem_ready`=1 → states FETCH, DECODE, EXECR, ALUWB; RegWrite in cycle 4; `instret`=1.
- `lw` with `mem_ready` low for 3 cycles in MEMRD → `mem_req` and AdrSrc=1 held; MEMWB after ready; 8 cycles total.
- bge with Lt=0 → PCWrite in BRANCH. Same with Lt=1 → no PCWrite. Both take 3 cycles and retire.
- JALR → PCWrite with ResultSrc=10 in JALR, then RegWrite with ALUSrcA=01, ALUSrcB=10 in JALWB.
- Preload `instret` to 2^CNT_W−1 via retires (CNT_W=4) → the 16th retire wraps it to 0.
- Opcode 0000000 → `illegal`=1 held with the macro defined; without it, back in FETCH with no retire. Reset mid-MEMWR → no further MemWrite.

Source files
------------

// File: rtl/mc_controlunit.sv
// ============================================================================
// Module   : mc_controlunit
// Purpose  : Multi-cycle RV32I control FSM (fetch/decode/execute/mem/wb) with
//            memory ready handshake, branch resolution and retire counter.
//            Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_controlunit #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             Zero,
    input  logic             Lt,
    input  logic             Ltu,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ImmSrc,
    output logic [3:0]       ALUControl,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] C_OP_STORE = 7'b0100011;
    localparam logic [6:0] C_OP_R     = 7'b0110011;
    localparam logic [6:0] C_OP_I     = 7'b0010011;
    localparam logic [6:0] C_OP_BR    = 7'b1100011;
    localparam logic [6:0] C_OP_JAL   = 7'b1101111;
    localparam logic [6:0] C_OP_JALR  = 7'b1100111;
    localparam logic [6:0] C_OP_LUI   = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC = 7'b0010111;

    localparam logic [3:0] C_ALU_ADD  = 4'd0;
    localparam logic [3:0] C_ALU_SUB  = 4'd1;
    localparam logic [3:0] C_ALU_AND  = 4'd2;
    localparam logic [3:0] C_ALU_OR   = 4'd3;
    localparam logic [3:0] C_ALU_XOR  = 4'd4;
    localparam logic [3:0] C_ALU_SLT  = 4'd5;
    localparam logic [3:0] C_ALU_SLTU = 4'd6;
    localparam logic [3:0] C_ALU_SLL  = 4'd7;
    localparam logic [3:0] C_ALU_SRL  = 4'd8;
    localparam logic [3:0] C_ALU_SRA  = 4'd9;
    localparam logic [3:0] C_ALU_PASSB = 4'd10;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXECR  = 4'd6,
        ST_EXECI  = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JAL    = 4'd10,
        ST_JALR   = 4'd11,
        ST_JALWB  = 4'd12,
        ST_LUI    = 4'd13,
        ST_AUIPC  = 4'd14,
        ST_TRAP   = 4'd15
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_run;
    logic [CNT_W-1:0] r_instret;
    logic             w_ready;
    logic             w_branch_take;
    logic [3:0]       w_alu_op;

    // r_run keeps every strobe low for the cycle after reset release, so the
    // first fetch request is raised on the first edge after deassertion.
    assign w_ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign instret = r_instret;

    always_comb begin
        case (funct3)
            3'b000:  w_branch_take = Zero;
            3'b001:  w_branch_take = ~Zero;
            3'b100:  w_branch_take = Lt;
            3'b101:  w_branch_take = ~Lt;
            3'b110:  w_branch_take = Ltu;
            3'b111:  w_branch_take = ~Ltu;
            default: w_branch_take = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  w_alu_op = (op == C_OP_R && funct7_5) ? C_ALU_SUB : C_ALU_ADD;
            3'b001:  w_alu_op = C_ALU_SLL;
            3'b010:  w_alu_op = C_ALU_SLT;
            3'b011:  w_alu_op = C_ALU_SLTU;
            3'b100:  w_alu_op = C_ALU_XOR;
            3'b101:  w_alu_op = funct7_5 ? C_ALU_SRA : C_ALU_SRL;
            3'b110:  w_alu_op = C_ALU_OR;
            default: w_alu_op = C_ALU_AND;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH:  if (r_run && w_ready) w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    C_OP_LOAD, C_OP_STORE: w_state_nxt = ST_MEMADR;
                    C_OP_R:                w_state_nxt = ST_EXECR;
                    C_OP_I:                w_state_nxt = ST_EXECI;
                    C_OP_BR:               w_state_nxt = ST_BRANCH;
                    C_OP_JAL:              w_state_nxt = ST_JAL;
                    C_OP_JALR:             w_state_nxt = ST_JALR;
                    C_OP_LUI:              w_state_nxt = ST_LUI;
                    C_OP_AUIPC:            w_state_nxt = ST_AUIPC;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:               w_state_nxt = ST_TRAP;
`else
                    default:               w_state_nxt = ST_FETCH;
`endif
                endcase
            end
            ST_MEMADR: w_state_nxt = (op == C_OP_STORE) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  if (w_ready) w_state_nxt = ST_MEMWB;
            ST_MEMWB:  w_state_nxt = ST_FETCH;
            ST_MEMWR:  if (w_ready) w_state_nxt = ST_FETCH;
            ST_EXECR,
            ST_EXECI:  w_state_nxt = ST_ALUWB;
            ST_ALUWB:  w_state_nxt = ST_FETCH;
            ST_BRANCH: w_state_nxt = ST_FETCH;
            ST_JAL:    w_state_nxt = ST_ALUWB;
            ST_JALR:   w_state_nxt = ST_JALWB;
            ST_JALWB:  w_state_nxt = ST_FETCH;
            ST_LUI,
            ST_AUIPC:  w_state_nxt = ST_ALUWB;
            ST_TRAP:   w_state_nxt = ST_TRAP;
            default:   w_state_nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = C_ALU_ADD;
        retire     = 1'b0;
        if (r_run) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = w_ready;
                    PCWrite   = w_ready;
                end
                ST_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (op == C_OP_JAL) ? 3'b011 : 3'b010;
                end
                ST_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (op == C_OP_STORE) ? 3'b001 : 3'b000;
                end
                ST_MEMRD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                ST_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                end
                ST_MEMWR: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                    retire   = w_ready;
                end
                ST_EXECR: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = w_alu_op;
                end
                ST_EXECI: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    ALUControl = w_alu_op;
                end
                ST_ALUWB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                ST_BRANCH: begin
                    ALUSrcA    = 2'b10;
                    ImmSrc     = 3'b010;
                    ALUControl = C_ALU_SUB;
                    PCWrite    = w_branch_take;
                    retire     = 1'b1;
                end
                ST_JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                ST_JALR: begin
                    ALUSrcA   = 2'b10;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                end
                ST_JALWB: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                end
                ST_LUI: begin
                    ALUSrcB    = 2'b01;
                    ImmSrc     = 3'b100;
                    ALUControl = C_ALU_PASSB;
                end
                ST_AUIPC: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = 3'b100;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal = r_run && (r_state == ST_TRAP);
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_run     <= 1'b0;
            r_instret <= '0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_state_nxt;
            if (retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_controlunit.sv
// Scoreboard bench for mc_controlunit: directed instructions push per-cycle
// expected control words, a negedge monitor pops and compares them.
`default_nettype none

module tb_mc_controlunit;

    localparam int CNT_W = 4;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // strobe vector {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, retire, illegal}
    localparam logic [7:0] S_REQ = 8'h80, S_MW = 8'h40, S_ADR = 8'h20, S_IR = 8'h10;
    localparam logic [7:0] S_PC  = 8'h08, S_RW = 8'h04, S_RET = 8'h02, S_ILL = 8'h01;
    localparam logic [4:0] C_RS = 5'h01, C_A = 5'h02, C_B = 5'h04, C_ALU = 5'h08, C_IMM = 5'h10;
    localparam logic [4:0] C_ALL = 5'h1f;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic funct7_5 = 1'b0, Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0, mem_ready = 1'b1;
    logic mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, retire, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [CNT_W-1:0] instret;

    mc_controlunit #(.MEM_HANDSHAKE(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .retire(retire), .instret(instret), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [7:0]       strb;
        logic [1:0]       rs;
        logic [1:0]       a;
        logic [1:0]       b;
        logic [3:0]       alu;
        logic [2:0]       imm;
        logic [4:0]       care;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        logic [7:0] act;
        logic bad;
        act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, retire, illegal};
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: expected record for cycle %0d was never compared", e.tag, e.cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            checks++;
            bad = (act !== e.strb) || (instret !== e.cnt)
                || (e.care[0] && ResultSrc !== e.rs) || (e.care[1] && ALUSrcA !== e.a)
                || (e.care[2] && ALUSrcB !== e.b) || (e.care[3] && ALUControl !== e.alu)
                || (e.care[4] && ImmSrc !== e.imm);
            if (bad) begin
                failures++;
                $display("FAIL %s cyc=%0d: got strb=%b rs=%b a=%b b=%b alu=%0d imm=%b instret=%0d, need strb=%b rs=%b a=%b b=%b alu=%0d imm=%b instret=%0d (care=%b)",
                         e.tag, cyc, act, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instret,
                         e.strb, e.rs, e.a, e.b, e.alu, e.imm, e.cnt, e.care);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input logic [7:0] strb, input logic [1:0] rs, input logic [1:0] a,
                              input logic [1:0] b, input logic [3:0] alu, input logic [2:0] imm,
                              input logic [4:0] care, input string tag);
        exp_t e;
        e.cyc = cyc; e.strb = strb; e.rs = rs; e.a = a; e.b = b;
        e.alu = alu; e.imm = imm; e.care = care; e.cnt = exp_cnt; e.tag = tag;
        q.push_back(e);
        if ((strb & S_RET) != 8'h00) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic load_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7_5 = f7;
    endtask

    task automatic do_fetch(input int stall);
        for (int i = 0; i < stall; i++) begin
            mem_ready = 1'b0;
            expect_cyc(S_REQ, 2'b10, 2'b00, 2'b10, 4'd0, 3'd0, C_RS | C_A | C_B | C_ALU, "fetch_wait");
            step();
        end
        mem_ready = 1'b1;
        expect_cyc(S_REQ | S_IR | S_PC, 2'b10, 2'b00, 2'b10, 4'd0, 3'd0, C_RS | C_A | C_B | C_ALU, "fetch");
        step();
    endtask

    task automatic do_decode(input logic [2:0] imm);
        expect_cyc(8'h00, 2'b00, 2'b01, 2'b01, 4'd0, imm, C_A | C_B | C_ALU | C_IMM, "decode");
        step();
    endtask

    task automatic do_aluwb();
        expect_cyc(S_RW | S_RET, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, C_RS, "aluwb");
        step();
    endtask

    task automatic run_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic [3:0] alu, input string tag);
        load_ir(o, f3, f7);
        do_fetch(0);
        do_decode(3'b010);
        if (o == OP_R) expect_cyc(8'h00, 2'b00, 2'b10, 2'b00, alu, 3'd0, C_A | C_B | C_ALU, tag);
        else           expect_cyc(8'h00, 2'b00, 2'b10, 2'b01, alu, 3'b000, C_A | C_B | C_ALU | C_IMM, tag);
        step();
        do_aluwb();
    endtask

    task automatic run_load(input int stall);
        load_ir(OP_LOAD, 3'b010, 1'b0);
        do_fetch(0);
        do_decode(3'b010);
        expect_cyc(8'h00, 2'b00, 2'b10, 2'b01, 4'd0, 3'b000, C_A | C_B | C_ALU | C_IMM, "memadr_ld");
        step();
        for (int i = 0; i < stall; i++) begin
            mem_ready = 1'b0;
            expect_cyc(S_REQ | S_ADR, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 5'h00, "memrd_wait");
            step();
        end
        mem_ready = 1'b1;
        expect_cyc(S_REQ | S_ADR, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 5'h00, "memrd");
        step();
        expect_cyc(S_RW | S_RET, 2'b01, 2'b00, 2'b00, 4'd0, 3'd0, C_RS, "memwb");
        step();
    endtask

    task automatic run_store(input int fstall, input int stall);
        load_ir(OP_STORE, 3'b010, 1'b0);
        do_fetch(fstall);
        do_decode(3'b010);
        expect_cyc(8'h00, 2'b00, 2'b10, 2'b01, 4'd0, 3'b001, C_A | C_B | C_ALU | C_IMM, "memadr_st");
        step();
        for (int i = 0; i < stall; i++) begin
            mem_ready = 1'b0;
            expect_cyc(S_REQ | S_MW | S_ADR, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 5'h00, "memwr_wait");
            step();
        end
        mem_ready = 1'b1;
        expect_cyc(S_REQ | S_MW | S_ADR | S_RET, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 5'h00, "memwr");
        step();
    endtask

    task automatic run_branch(input logic [2:0] f3, input logic z, input logic lt,
                              input logic ltu, input logic taken, input string tag);
        load_ir(OP_BR, f3, 1'b0);
        do_fetch(0);
        do_decode(3'b010);
        Zero = z; Lt = lt; Ltu = ltu;
        expect_cyc((taken ? S_PC : 8'h00) | S_RET, 2'b00, 2'b10, 2'b00, 4'd1, 3'd0,
                   C_RS | C_A | C_B | C_ALU, tag);
        step();
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
    endtask

    task automatic run_jumps_upper();
        load_ir(OP_JALR, 3'b000, 1'b0);
        do_fetch(0);
        do_decode(3'b010);
        expect_cyc(S_PC, 2'b10, 2'b10, 2'b01, 4'd0, 3'b000, C_ALL, "jalr");
        step();
        expect_cyc(S_RW | S_RET, 2'b10, 2'b01, 2'b10, 4'd0, 3'd0, C_RS | C_A | C_B | C_ALU, "jalwb");
        step();
        load_ir(OP_JAL, 3'b000, 1'b0);
        do_fetch(0);
        do_decode(3'b011);
        expect_cyc(S_PC, 2'b00, 2'b01, 2'b10, 4'd0, 3'd0, C_RS | C_A | C_B | C_ALU, "jal");
        step();
        do_aluwb();
        load_ir(OP_LUI, 3'b000, 1'b0);
        do_fetch(0);
        do_decode(3'b010);
        expect_cyc(8'h00, 2'b00, 2'b00, 2'b01, 4'd10, 3'b100, C_B | C_ALU | C_IMM, "lui");
        step();
        do_aluwb();
        load_ir(OP_AUIPC, 3'b000, 1'b0);
        do_fetch(0);
        do_decode(3'b010);
        expect_cyc(8'h00, 2'b00, 2'b01, 2'b01, 4'd0, 3'b100, C_A | C_B | C_ALU | C_IMM, "auipc");
        step();
        do_aluwb();
    endtask

    initial begin
        step();
        step();
        expect_cyc(8'h00, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, C_ALL, "reset");
        step();
        rst_n = 1'b1;
        step();

        run_alu(OP_R, 3'b000, 1'b0, 4'd0, "add");
        run_load(3);
        run_branch(3'b101, 1'b0, 1'b0, 1'b0, 1'b1, "bge_taken");
        run_branch(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, "bge_not");
        run_jumps_upper();
        run_alu(OP_R, 3'b000, 1'b1, 4'd1, "sub");
        run_alu(OP_I, 3'b000, 1'b1, 4'd0, "addi_bit30");
        run_alu(OP_R, 3'b101, 1'b1, 4'd9, "sra");
        run_alu(OP_I, 3'b101, 1'b0, 4'd8, "srli");
        run_alu(OP_I, 3'b011, 1'b0, 4'd6, "sltiu");
        run_store(2, 1);
        run_branch(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, "beq_taken");
        run_branch(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, "bne_not");
        run_branch(3'b010, 1'b1, 1'b1, 1'b1, 1'b0, "f3_010_never");
        run_branch(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, "bgeu_not");
        run_branch(3'b110, 1'b0, 1'b0, 1'b1, 1'b1, "bltu_taken");
        run_alu(OP_R, 3'b111, 1'b0, 4'd2, "and");
        run_alu(OP_I, 3'b110, 1'b0, 4'd3, "ori");
        run_alu(OP_R, 3'b001, 1'b0, 4'd7, "sll");
        run_alu(OP_R, 3'b010, 1'b0, 4'd5, "slt");
        run_alu(OP_R, 3'b100, 1'b0, 4'd4, "xor");

        load_ir(7'b0000000, 3'b000, 1'b0);
        do_fetch(0);
        do_decode(3'b010);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            expect_cyc(S_ILL, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, C_ALL, "trap");
            step();
        end
        rst_n = 1'b0;
        exp_cnt = '0;
        expect_cyc(8'h00, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, C_ALL, "trap_reset");
        step();
        rst_n = 1'b1;
        step();
`endif
        run_alu(OP_R, 3'b000, 1'b0, 4'd0, "add_after_bad");

        load_ir(OP_STORE, 3'b010, 1'b0);
        do_fetch(0);
        do_decode(3'b010);
        expect_cyc(8'h00, 2'b00, 2'b10, 2'b01, 4'd0, 3'b001, C_A | C_B | C_ALU | C_IMM, "memadr_rst");
        step();
        mem_ready = 1'b0;
        expect_cyc(S_REQ | S_MW | S_ADR, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 5'h00, "memwr_before_rst");
        step();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        exp_cnt = '0;
        expect_cyc(8'h00, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, C_ALL, "reset_mid_memwr");
        step();
        rst_n = 1'b1;
        step();
        run_alu(OP_I, 3'b100, 1'b0, 4'd4, "xori_after_rst");

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d records left uncompared, need 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
